// File: rtl/hovalaag_host_driver.sv
// hovalaag_host_driver
//   Host-side sequencer for the Hovalaag wrapper bus. It takes one command
//   (32-bit instruction plus IN1/IN2) and writes it into the wrapper six bits
//   at a time. It then pulses execute, reads back status, PC and OUT, and
//   returns them on a valid/ready response port.
//
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready=1, bus idle
//   W_IN1L | write IN1[5:0]         (addr bit 6)
//   W_IN1H | write IN1[11:6]        (addr bit 7)
//   W_IN2L | write IN2[5:0]         (addr bit 8)
//   W_IN2H | write IN2[11:6]        (addr bit 9)
//   W_I0-4 | write instr[6k+5:6k]   (addr bits 0..4)
//   EXEC   | execute, instr[31:30]  (addr bit 5), always 1 cycle, status read
//   R_PC   | read PC                (addr bit 6)
//   R_OL   | read OUT[7:0]          (addr bit 7)
//   R_OH   | read OUT[11:8]         (addr bit 8)
//   RESP   | response held until rsp_ready, bus idle
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/ready/instr/in1/in2  command port
//   rsp_valid/ready/status/pc/out  response port
//   hv_addr, hv_io_in           registered one-hot address and data to wrapper
//   hv_io_out                   read data from wrapper
module hovalaag_host_driver #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_instr,
    input  logic [11:0] cmd_in1,
    input  logic [11:0] cmd_in2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_status,
    output logic [7:0]  rsp_pc,
    output logic [11:0] rsp_out,
    output logic [9:0]  hv_addr,
    output logic [5:0]  hv_io_in,
    input  logic [7:0]  hv_io_out
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_IN1L, S_W_IN1H, S_W_IN2L, S_W_IN2H,
        S_W_I0, S_W_I1, S_W_I2, S_W_I3, S_W_I4,
        S_EXEC, S_R_PC, S_R_OL, S_R_OH, S_RESP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] hold_cnt, hold_next;
    logic [31:0]   instr_q;
    logic [11:0]   in1_q, in2_q;
    logic          accept;
    logic          phase_done;

    // Sources for the next bus value: on the accept edge the latches are not
    // loaded yet, so the first phase is decoded from the command inputs.
    logic [31:0]   instr_src;
    logic [11:0]   in1_src, in2_src;
    logic [9:0]    addr_next;
    logic [5:0]    io_next;

    assign cmd_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign accept     = cmd_valid && cmd_ready;
    assign phase_done = (hold_cnt == '0);

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_W_IN1L;
                    hold_next  = HOLD_LOAD;
                end
            end
            S_EXEC: begin
                state_next = S_R_PC;
                hold_next  = HOLD_LOAD;
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: begin
                if (phase_done) begin
                    case (state)
                        S_W_IN1L: state_next = S_W_IN1H;
                        S_W_IN1H: state_next = S_W_IN2L;
                        S_W_IN2L: state_next = S_W_IN2H;
                        S_W_IN2H: state_next = S_W_I0;
                        S_W_I0:   state_next = S_W_I1;
                        S_W_I1:   state_next = S_W_I2;
                        S_W_I2:   state_next = S_W_I3;
                        S_W_I3:   state_next = S_W_I4;
                        S_W_I4:   state_next = S_EXEC;
                        S_R_PC:   state_next = S_R_OL;
                        S_R_OL:   state_next = S_R_OH;
                        S_R_OH:   state_next = S_RESP;
                        default:  state_next = S_IDLE;
                    endcase
                    // EXEC is single-cycle: each enabled cycle executes once.
                    hold_next = (state_next == S_EXEC) ? '0 : HOLD_LOAD;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        instr_src = accept ? cmd_instr : instr_q;
        in1_src   = accept ? cmd_in1   : in1_q;
        in2_src   = accept ? cmd_in2   : in2_q;
        addr_next = '0;
        io_next   = '0;
        // Read phases reuse the IN addresses; the wrapper treats them as
        // writes, so the loaded IN values are presented again to keep them.
        case (state_next)
            S_W_IN1L, S_R_PC: begin addr_next = 10'b0001000000; io_next = in1_src[5:0];   end
            S_W_IN1H, S_R_OL: begin addr_next = 10'b0010000000; io_next = in1_src[11:6];  end
            S_W_IN2L, S_R_OH: begin addr_next = 10'b0100000000; io_next = in2_src[5:0];   end
            S_W_IN2H: begin addr_next = 10'b1000000000; io_next = in2_src[11:6];  end
            S_W_I0:   begin addr_next = 10'b0000000001; io_next = instr_src[5:0];   end
            S_W_I1:   begin addr_next = 10'b0000000010; io_next = instr_src[11:6];  end
            S_W_I2:   begin addr_next = 10'b0000000100; io_next = instr_src[17:12]; end
            S_W_I3:   begin addr_next = 10'b0000001000; io_next = instr_src[23:18]; end
            S_W_I4:   begin addr_next = 10'b0000010000; io_next = instr_src[29:24]; end
            S_EXEC:   begin addr_next = 10'b0000100000; io_next = {4'b0, instr_src[31:30]}; end
            default:  begin addr_next = '0; io_next = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            hv_addr    <= '0;
            hv_io_in   <= '0;
            instr_q    <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            rsp_status <= '0;
            rsp_pc     <= '0;
            rsp_out    <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            hv_addr  <= addr_next;
            hv_io_in <= io_next;
            if (accept) begin
                instr_q <= cmd_instr;
                in1_q   <= cmd_in1;
                in2_q   <= cmd_in2;
            end
            // Reads sample on the last hold cycle so early bus glitches are ignored.
            if (state == S_EXEC)
                rsp_status <= hv_io_out[3:0];
            if (state == S_R_PC && phase_done)
                rsp_pc <= hv_io_out;
            if (state == S_R_OL && phase_done)
                rsp_out[7:0] <= hv_io_out;
            if (state == S_R_OH && phase_done)
                rsp_out[11:8] <= hv_io_out[3:0];
        end
    end

endmodule

// File: tb/tb_hovalaag_host_driver.sv
module tb_hovalaag_host_driver;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // DUT with HOLD_CYCLES=1
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [31:0] cmd_instr;
    logic [11:0] cmd_in1, cmd_in2, rsp_out;
    logic [3:0]  rsp_status;
    logic [7:0]  rsp_pc, hv_io_out;
    logic [9:0]  hv_addr;
    logic [5:0]  hv_io_in;

    // DUT with HOLD_CYCLES=3
    logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3;
    logic [31:0] cmd_instr3;
    logic [11:0] cmd_in13, cmd_in23, rsp_out3;
    logic [3:0]  rsp_status3;
    logic [7:0]  rsp_pc3, hv_io_out3;
    logic [9:0]  hv_addr3, prev_addr3;
    logic [5:0]  hv_io_in3;

    hovalaag_host_driver #(.HOLD_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_pc(rsp_pc), .rsp_out(rsp_out),
        .hv_addr(hv_addr), .hv_io_in(hv_io_in), .hv_io_out(hv_io_out)
    );

    hovalaag_host_driver #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_instr(cmd_instr3),
        .cmd_in1(cmd_in13), .cmd_in2(cmd_in23),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_status(rsp_status3),
        .rsp_pc(rsp_pc3), .rsp_out(rsp_out3),
        .hv_addr(hv_addr3), .hv_io_in(hv_io_in3), .hv_io_out(hv_io_out3)
    );

    // Wrapper model for dut: PC advances on each execute cycle, IN registers
    // are written whenever their address is presented.
    logic [7:0]  model_pc, pc_seed;
    logic        pc_load;
    logic [11:0] m_in1, m_in2;

    always @(posedge clk) begin
        if (pc_load)         model_pc <= pc_seed;
        else if (hv_addr[5]) model_pc <= model_pc + 8'd1;
        if (hv_addr[6]) m_in1[5:0]  <= hv_io_in;
        if (hv_addr[7]) m_in1[11:6] <= hv_io_in;
        if (hv_addr[8]) m_in2[5:0]  <= hv_io_in;
        if (hv_addr[9]) m_in2[11:6] <= hv_io_in;
    end

    always_comb begin
        hv_io_out = 8'h00;
        if (hv_addr[5])      hv_io_out = 8'hA5;
        else if (hv_addr[6]) hv_io_out = model_pc;
        else if (hv_addr[7]) hv_io_out = 8'h5A;
        else if (hv_addr[8]) hv_io_out = 8'hF3;
    end

    // Model for dut3: the first R_PC cycle (right after execute) glitches.
    always @(posedge clk) prev_addr3 <= hv_addr3;
    always_comb begin
        hv_io_out3 = 8'h00;
        if (hv_addr3[6]) hv_io_out3 = prev_addr3[5] ? 8'hEE : 8'h17;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int exp_bit [13] = '{6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    logic [5:0] exp_io [13] = '{6'h3C, 6'h2A, 6'h23, 6'h04, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h03, 6'h3C, 6'h2A, 6'h23};

    initial begin
        logic [3:0]  s_status;
        logic [7:0]  s_pc;
        logic [11:0] s_out;
        logic        found;
        int          lat, nresp, nexec;

        reset = 1'b1;
        cmd_valid = 0; cmd_instr = 0; cmd_in1 = 0; cmd_in2 = 0; rsp_ready = 0;
        cmd_valid3 = 0; cmd_instr3 = 0; cmd_in13 = 0; cmd_in23 = 0; rsp_ready3 = 0;
        pc_load = 1'b1; pc_seed = 8'h16;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; pc_load = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_hv_addr", hv_addr, 0);
        check("rst_hv_io_in", hv_io_in, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_pc", rsp_pc, 0);
        check("rst_rsp_out", rsp_out, 0);

        // Phase walk and readback, HOLD_CYCLES=1
        cmd_instr = 32'hC0000000; cmd_in1 = 12'hABC; cmd_in2 = 12'h123;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("walk_addr%0d", i), hv_addr, 10'(1) << exp_bit[i]);
            check($sformatf("walk_io%0d", i), hv_io_in, exp_io[i]);
            if (i == 12) check("walk_rsp_early", rsp_valid, 0);
            @(negedge clk);
        end
        check("latency14", rsp_valid, 1);
        check("rd_status", rsp_status, 4'h5);
        check("rd_pc", rsp_pc, 8'h17);
        check("rd_out", rsp_out, 12'h35A);
        check("in1_kept", m_in1, 12'hABC);
        check("in2_kept", m_in2, 12'h123);

        // Backpressure
        s_status = rsp_status; s_pc = rsp_pc; s_out = rsp_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_hv_addr", hv_addr, 0);
            check("bp_status", rsp_status, s_status);
            check("bp_pc", rsp_pc, s_pc);
            check("bp_out", rsp_out, s_out);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_done_cmd_ready", cmd_ready, 1);
        check("bp_done_rsp_valid", rsp_valid, 0);

        // HOLD_CYCLES=3 with glitch on first R_PC cycle
        cmd_instr3 = 32'h12345678; cmd_in13 = 12'hABC; cmd_in23 = 12'h123;
        cmd_valid3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            for (int r = 0; r < ((k == 9) ? 1 : 3); r++) begin
                check($sformatf("h3_addr%0d_%0d", k, r), hv_addr3, 10'(1) << exp_bit[k]);
                @(negedge clk);
            end
        end
        check("h3_latency38", rsp_valid3, 1);
        check("h3_glitch_pc", rsp_pc3, 8'h17);
        rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;
        check("h3_idle", cmd_ready3, 1);

        // Reset during W_I2
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (hv_addr == 10'b0000000100) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("mid_found_wi2", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_hv_addr", hv_addr, 0);
        check("mid_hv_io_in", hv_io_in, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_rsp_valid", rsp_valid, 0);
        cmd_instr = 32'h0000003F;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("restart_addr", hv_addr, 10'b0001000000);
        check("restart_io", hv_io_in, 6'h3C);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("restart_latency", lat, 14);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Back-to-back commands with cmd_valid held
        pc_load = 1'b1; pc_seed = 8'h40;
        @(negedge clk);
        pc_load = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        nresp = 0; nexec = 0;
        for (int t = 0; t < 100 && nresp < 3; t++) begin
            if (hv_addr == 10'b0000100000) nexec++;
            if (rsp_valid) begin
                check($sformatf("b2b_pc%0d", nresp), rsp_pc, 8'h41 + 8'(nresp));
                check($sformatf("b2b_exec%0d", nresp), nexec, 1);
                nexec = 0;
                nresp++;
                if (nresp == 3) cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_responses", nresp, 3);
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
